// File: rtl/pipe_mips_core.sv
// Five-stage in-order MIPS-style core sharing one word-addressed memory for code and data.
// FWD_EN selects EX-stage operand forwarding; otherwise ID waits until producers reach writeback.
module pipe_mips_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ = 6'b001110, OP_HLT  = 6'b111111;
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] regs [32];

  logic [ADDR_W-1:0] pc;
  logic              halt_seen;
  logic              ifid_v;
  logic [31:0]       ifid_ir;
  logic [ADDR_W-1:0] ifid_npc;
  logic              idex_v, idex_wen;
  logic [5:0]        idex_op;
  logic [4:0]        idex_rs, idex_rt, idex_dst;
  logic [DATA_W-1:0] idex_a, idex_b, idex_imm;
  logic [ADDR_W-1:0] idex_npc;
  logic              exmem_v, exmem_wen;
  logic [5:0]        exmem_op;
  logic [4:0]        exmem_dst;
  logic [DATA_W-1:0] exmem_alu, exmem_b;
  logic              memwb_v, memwb_wen, memwb_hlt;
  logic [4:0]        memwb_dst;
  logic [DATA_W-1:0] memwb_val;

  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt, id_dst;
  logic              id_wen, id_use_rs, id_use_rt, id_hlt;
  logic [DATA_W-1:0] id_imm, id_a, id_b;
  logic              ex_hit, mem_hit, id_stall, wb_we, br_taken, id_adv;
  logic [DATA_W-1:0] ex_a, ex_b, ex_res, mem_val;
  logic [ADDR_W-1:0] br_target;

  assign busy      = (state == S_RUN);
  assign halted    = (state == S_HALTED);
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALTED: if (start) state_next = S_RUN;
      S_RUN:            if (memwb_v && memwb_hlt) state_next = S_HALTED;
      default:          state_next = S_IDLE;
    endcase
  end

  // Decode; any opcode outside the defined set behaves as HLT.
  always_comb begin
    id_op = ifid_ir[31:26];
    case (ifid_ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_LW, OP_SW,
      OP_ADDI, OP_SUBI, OP_SLTI, OP_BNEQZ, OP_BEQZ: id_op = ifid_ir[31:26];
      default: id_op = OP_HLT;
    endcase
    id_rs     = ifid_ir[25:21];
    id_rt     = ifid_ir[20:16];
    id_imm    = {{(DATA_W-16){ifid_ir[15]}}, ifid_ir[15:0]};
    id_dst    = id_rt;
    id_wen    = 1'b0;
    id_use_rs = 1'b1;
    id_use_rt = 1'b0;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_wen    = 1'b1;
        id_dst    = ifid_ir[15:11];
        id_use_rt = 1'b1;
      end
      OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: id_wen = 1'b1;
      OP_SW:  id_use_rt = 1'b1;
      OP_HLT: id_use_rs = 1'b0;
      default: ;
    endcase
  end

  // Register file reads see a same-cycle writeback.
  assign wb_we = (state == S_RUN) && memwb_v && memwb_wen && (memwb_dst != 5'd0);
  assign id_a  = (id_rs == 5'd0) ? '0 : (wb_we && memwb_dst == id_rs) ? memwb_val : regs[id_rs];
  assign id_b  = (id_rt == 5'd0) ? '0 : (wb_we && memwb_dst == id_rt) ? memwb_val : regs[id_rt];

  assign ex_hit  = idex_v && idex_wen && (idex_dst != 5'd0) &&
                   ((id_use_rs && idex_dst == id_rs) || (id_use_rt && idex_dst == id_rt));
  assign mem_hit = exmem_v && exmem_wen && (exmem_dst != 5'd0) &&
                   ((id_use_rs && exmem_dst == id_rs) || (id_use_rt && exmem_dst == id_rt));
  assign id_stall = ifid_v && ((FWD_EN != 0) ? (ex_hit && idex_op == OP_LW) : (ex_hit || mem_hit));
  assign id_hlt   = ifid_v && (id_op == OP_HLT);
  assign id_adv   = ifid_v && !id_stall && !br_taken;

  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    if (FWD_EN != 0) begin
      if (exmem_v && exmem_wen && exmem_dst != 5'd0 && exmem_dst == idex_rs)      ex_a = exmem_alu;
      else if (memwb_v && memwb_wen && memwb_dst != 5'd0 && memwb_dst == idex_rs) ex_a = memwb_val;
      if (exmem_v && exmem_wen && exmem_dst != 5'd0 && exmem_dst == idex_rt)      ex_b = exmem_alu;
      else if (memwb_v && memwb_wen && memwb_dst != 5'd0 && memwb_dst == idex_rt) ex_b = memwb_val;
    end
  end

  always_comb begin
    case (idex_op)
      OP_ADD:                 ex_res = ex_a + ex_b;
      OP_SUB:                 ex_res = ex_a - ex_b;
      OP_AND:                 ex_res = ex_a & ex_b;
      OP_OR:                  ex_res = ex_a | ex_b;
      OP_SLT:                 ex_res = {{(DATA_W-1){1'b0}}, (ex_a < ex_b)};
      OP_MUL:                 ex_res = ex_a * ex_b;
      OP_LW, OP_SW, OP_ADDI:  ex_res = ex_a + idex_imm;
      OP_SUBI:                ex_res = ex_a - idex_imm;
      OP_SLTI:                ex_res = {{(DATA_W-1){1'b0}}, (ex_a < idex_imm)};
      default:                ex_res = '0;
    endcase
  end

  assign br_taken  = idex_v && ((idex_op == OP_BEQZ  && ex_a == '0) ||
                                (idex_op == OP_BNEQZ && ex_a != '0));
  assign br_target = idex_npc + idex_imm[ADDR_W-1:0];
  assign mem_val   = (exmem_op == OP_LW) ? mem[exmem_alu[ADDR_W-1:0]] : exmem_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0; halt_seen <= 1'b0; retired <= '0;
      ifid_v <= 1'b0; idex_v <= 1'b0; exmem_v <= 1'b0; memwb_v <= 1'b0;
    end else if (state != S_RUN) begin
      if (start) begin
        pc <= '0; halt_seen <= 1'b0; retired <= '0;
        ifid_v <= 1'b0; idex_v <= 1'b0; exmem_v <= 1'b0; memwb_v <= 1'b0;
      end
    end else begin
      if (memwb_v && retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
      memwb_v   <= exmem_v;
      memwb_hlt <= (exmem_op == OP_HLT);
      memwb_wen <= exmem_wen;
      memwb_dst <= exmem_dst;
      memwb_val <= mem_val;
      exmem_v   <= idex_v;
      exmem_op  <= idex_op;
      exmem_wen <= idex_wen;
      exmem_dst <= idex_dst;
      exmem_alu <= ex_res;
      exmem_b   <= ex_b;
      idex_v    <= id_adv;
      idex_op   <= id_op;
      idex_wen  <= id_wen;
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_dst  <= id_dst;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= id_imm;
      idex_npc  <= ifid_npc;
      if (id_adv && id_op == OP_HLT) halt_seen <= 1'b1;
      // Taken branch wins over stall and halt; a HLT still in ID is squashed here.
      if (br_taken) begin
        pc     <= br_target;
        ifid_v <= 1'b0;
      end else if (!id_stall) begin
        if (halt_seen || id_hlt) begin
          ifid_v <= 1'b0;
        end else begin
          ifid_v   <= 1'b1;
          ifid_ir  <= mem[pc][31:0];
          ifid_npc <= pc + PC_ONE;
          pc       <= pc + PC_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state != S_RUN) begin
      if (prog_we) mem[prog_addr] <= prog_wdata;
    end else if (exmem_v && exmem_op == OP_SW) begin
      mem[exmem_alu[ADDR_W-1:0]] <= exmem_b;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_we) regs[memwb_dst] <= memwb_val;
  end

endmodule

// File: tb/tb_pipe_mips_core.sv
// Directed bench: three cores (32-bit forwarding, 32-bit stalling, 64-bit forwarding) run the same programs.
module tb_pipe_mips_core;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [63:0] prog_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [2:0]        busy_v, halt_v;
  logic [2:0][31:0]  ret_v;
  logic [2:0][63:0]  dbg_v;
  int checks = 0;
  int errors = 0;
  int cyc [3];

  always #5 clk = ~clk;

  assign dbg_v[0][63:32] = '0;
  assign dbg_v[1][63:32] = '0;

  pipe_mips_core #(.DATA_W(32), .ADDR_W(10), .FWD_EN(1)) u_f1 (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata[31:0]), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_v[0][31:0]),
    .busy(busy_v[0]), .halted(halt_v[0]), .retired(ret_v[0]));
  pipe_mips_core #(.DATA_W(32), .ADDR_W(10), .FWD_EN(0)) u_f0 (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata[31:0]), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_v[1][31:0]),
    .busy(busy_v[1]), .halted(halt_v[1]), .retired(ret_v[1]));
  pipe_mips_core #(.DATA_W(64), .ADDR_W(10), .FWD_EN(1)) u_w (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_v[2]),
    .busy(busy_v[2]), .halted(halt_v[2]), .retired(ret_v[2]));

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, rt, rd);
    enc_r = {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input int imm);
    enc_i = {op, rs, rt, 16'(imm)};
  endfunction

  // Drivers: called at posedge+1, return at posedge+1.
  task automatic load_word(input logic [9:0] a, input logic [63:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(posedge clk); #1 prog_we = 1'b0;
  endtask

  task automatic run_prog();
    int  cnt;
    bit  done;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int d = 0; d < 3; d++) cyc[d] = -1;
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      done = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (halt_v[d] && cyc[d] < 0) cyc[d] = cnt;
        if (cyc[d] < 0) done = 1'b0;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL run_timeout cycles %0d limit 400", cnt); end
  endtask

  task automatic read_mem(input logic [9:0] a);
    load_word(10'd0, {32'd0, enc_i(LW, 5'd0, 5'd7, int'(a))});
    load_word(10'd1, {32'd0, HLT, 26'd0});
    run_prog();
    dbg_raddr = 5'd7; #1;
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || halt_v[d] !== 1'b0 || ret_v[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d busy %b halted %b retired %0d exp 0 0 0",
                 d, busy_v[d], halt_v[d], ret_v[d]);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_chain();
    int exp_cyc [3];
    exp_cyc = '{8, 10, 8};
    load_word(10'd0, {32'd0, enc_i(ADDI, 5'd0, 5'd1, 10)});
    load_word(10'd1, {32'd0, enc_i(ADDI, 5'd0, 5'd2, 20)});
    load_word(10'd2, {32'd0, enc_r(ADD, 5'd1, 5'd2, 5'd3)});
    load_word(10'd3, {32'd0, HLT, 26'd0});
    run_prog();
    dbg_raddr = 5'd3; #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dbg_v[d] !== 64'd30) begin errors++; $display("FAIL alu_r3 dut%0d got %0d exp 30", d, dbg_v[d]); end
      checks++;
      if (ret_v[d] !== 32'd4) begin errors++; $display("FAIL alu_retired dut%0d got %0d exp 4", d, ret_v[d]); end
      checks++;
      if (halt_v[d] !== 1'b1 || busy_v[d] !== 1'b0) begin
        errors++; $display("FAIL alu_halted dut%0d halted %b busy %b exp 1 0", d, halt_v[d], busy_v[d]);
      end
      checks++;
      if (cyc[d] != exp_cyc[d]) begin errors++; $display("FAIL alu_cycles dut%0d got %0d exp %0d", d, cyc[d], exp_cyc[d]); end
    end
  endtask

  task automatic test_load_use();
    int exp_cyc [3];
    exp_cyc = '{9, 12, 9};
    load_word(10'd100, 64'd85);
    load_word(10'd0, {32'd0, enc_i(LW,   5'd0, 5'd2, 100)});
    load_word(10'd1, {32'd0, enc_i(ADDI, 5'd2, 5'd3, 45)});
    load_word(10'd2, {32'd0, enc_i(SW,   5'd0, 5'd3, 101)});
    load_word(10'd3, {32'd0, HLT, 26'd0});
    run_prog();
    dbg_raddr = 5'd3; #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dbg_v[d] !== 64'd130) begin errors++; $display("FAIL ldu_r3 dut%0d got %0d exp 130", d, dbg_v[d]); end
      checks++;
      if (cyc[d] != exp_cyc[d]) begin errors++; $display("FAIL ldu_cycles dut%0d got %0d exp %0d", d, cyc[d], exp_cyc[d]); end
      checks++;
      if (ret_v[d] !== 32'd4) begin errors++; $display("FAIL ldu_retired dut%0d got %0d exp 4", d, ret_v[d]); end
    end
    read_mem(10'd101);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dbg_v[d] !== 64'd130) begin errors++; $display("FAIL ldu_mem101 dut%0d got %0d exp 130", d, dbg_v[d]); end
    end
  endtask

  task automatic test_branch_loop();
    logic [4:0]  ridx [3];
    logic [63:0] rexp [3];
    ridx = '{5'd2, 5'd3, 5'd6};
    rexp = '{64'd120, 64'd0, 64'd1};
    load_word(10'd0, {32'd0, enc_i(ADDI,  5'd0, 5'd2, 1)});
    load_word(10'd1, {32'd0, enc_i(ADDI,  5'd0, 5'd3, 5)});
    load_word(10'd2, {32'd0, enc_i(ADDI,  5'd0, 5'd6, 0)});
    load_word(10'd3, {32'd0, enc_r(MUL,   5'd2, 5'd3, 5'd2)});
    load_word(10'd4, {32'd0, enc_i(SUBI,  5'd3, 5'd3, 1)});
    load_word(10'd5, {32'd0, enc_i(BNEQZ, 5'd3, 5'd0, -3)});
    load_word(10'd6, {32'd0, enc_i(ADDI,  5'd6, 5'd6, 1)});
    load_word(10'd7, {32'd0, HLT, 26'd0});
    run_prog();
    for (int r = 0; r < 3; r++) begin
      dbg_raddr = ridx[r]; #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dbg_v[d] !== rexp[r]) begin
          errors++; $display("FAIL loop_r%0d dut%0d got %0d exp %0d", ridx[r], d, dbg_v[d], rexp[r]);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ret_v[d] !== 32'd20) begin errors++; $display("FAIL loop_retired dut%0d got %0d exp 20", d, ret_v[d]); end
    end
  endtask

  task automatic test_misc_ops();
    logic [4:0]  ridx [7];
    logic [63:0] rexp [7];
    logic [63:0] e;
    ridx = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    rexp = '{64'd0, 64'd2, 64'd8, 64'd14, 64'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8};
    load_word(10'd0,  {32'd0, enc_i(ADDI, 5'd0, 5'd1, 12)});
    load_word(10'd1,  {32'd0, enc_i(ADDI, 5'd0, 5'd2, 10)});
    load_word(10'd2,  {32'd0, enc_i(ADDI, 5'd0, 5'd8, 3)});
    load_word(10'd3,  {32'd0, enc_r(SUB,  5'd1, 5'd2, 5'd3)});
    load_word(10'd4,  {32'd0, enc_r(AND_, 5'd1, 5'd2, 5'd4)});
    load_word(10'd5,  {32'd0, enc_r(OR_,  5'd1, 5'd2, 5'd5)});
    load_word(10'd6,  {32'd0, enc_i(SLTI, 5'd1, 5'd6, 13)});
    load_word(10'd7,  {32'd0, enc_i(ADDI, 5'd0, 5'd0, 5)});
    load_word(10'd8,  {32'd0, enc_i(BEQZ, 5'd0, 5'd0, 1)});
    load_word(10'd9,  {32'd0, HLT, 26'd0});
    load_word(10'd10, {32'd0, enc_i(SUBI, 5'd1, 5'd9, 20)});
    load_word(10'd11, {32'd0, 6'b010000, 26'd0});
    load_word(10'd12, {32'd0, enc_i(ADDI, 5'd0, 5'd8, 55)});
    run_prog();
    for (int r = 0; r < 7; r++) begin
      dbg_raddr = ridx[r]; #1;
      for (int d = 0; d < 3; d++) begin
        e = (d == 2) ? rexp[r] : (rexp[r] & 64'h0000_0000_FFFF_FFFF);
        checks++;
        if (dbg_v[d] !== e) begin
          errors++; $display("FAIL misc_r%0d dut%0d got %0h exp %0h", ridx[r], d, dbg_v[d], e);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ret_v[d] !== 32'd11) begin errors++; $display("FAIL misc_retired dut%0d got %0d exp 11", d, ret_v[d]); end
    end
  endtask

  task automatic test_wide();
    logic [63:0] e;
    load_word(10'd0, {32'd0, enc_i(ADDI, 5'd0, 5'd1, -1)});
    load_word(10'd1, {32'd0, enc_r(MUL,  5'd1, 5'd1, 5'd2)});
    load_word(10'd2, {32'd0, enc_r(SLT,  5'd0, 5'd1, 5'd3)});
    load_word(10'd3, {32'd0, HLT, 26'd0});
    run_prog();
    for (int r = 1; r < 4; r++) begin
      dbg_raddr = 5'(r); #1;
      for (int d = 0; d < 3; d++) begin
        e = (r != 1) ? 64'd1 : (d == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        checks++;
        if (dbg_v[d] !== e) begin errors++; $display("FAIL wide_r%0d dut%0d got %0h exp %0h", r, d, dbg_v[d], e); end
      end
    end
  endtask

  task automatic test_reset_abort();
    load_word(10'd200, 64'd11);
    load_word(10'd300, 64'd5);
    load_word(10'd0, {32'd0, enc_i(ADDI, 5'd0, 5'd1, 77)});
    load_word(10'd1, {32'd0, enc_i(SW,   5'd0, 5'd1, 200)});
    load_word(10'd2, {32'd0, HLT, 26'd0});
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    prog_we = 1'b1; prog_addr = 10'd300; prog_wdata = 64'd999;
    @(posedge clk); #1 prog_we = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || halt_v[d] !== 1'b0 || ret_v[d] !== 32'd0) begin
        errors++;
        $display("FAIL abort_outputs dut%0d busy %b halted %b retired %0d exp 0 0 0",
                 d, busy_v[d], halt_v[d], ret_v[d]);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    read_mem(10'd200);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dbg_v[d] !== 64'd11) begin errors++; $display("FAIL abort_mem200 dut%0d got %0d exp 11", d, dbg_v[d]); end
    end
    read_mem(10'd300);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dbg_v[d] !== 64'd5) begin errors++; $display("FAIL runwe_mem300 dut%0d got %0d exp 5", d, dbg_v[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_branch_loop();
    test_misc_ops();
    test_wide();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
